// File: rtl/boot_rom_pkg.sv
// Shared constants and the response record for the boot ROM fetch adapter.
package boot_rom_pkg;

  localparam int unsigned ROM_WORDS      = 800;
  localparam logic [31:0] BOOT_BASE_ADDR = 32'h0000_8000;
  localparam int          ROM_AW         = 10;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } rom_resp_t;

endpackage

// File: rtl/boot_rom_resp_fifo.sv
// Small response FIFO of rom_resp_t; pointers wrap modulo DEPTH so any depth works.
module boot_rom_resp_fifo
  import boot_rom_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic          CLK,
  input  logic          RSTN,
  input  logic          push,
  input  rom_resp_t     push_data,
  input  logic          pop,
  output rom_resp_t     head,
  output logic [CW-1:0] occ,
  output logic          empty
);

  rom_resp_t     mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign empty  = (occ == '0);
  assign do_pop = pop & ~empty;
  assign head   = mem[rd_ptr];

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ptr_inc(wr_ptr);
      end
      if (do_pop) rd_ptr <= ptr_inc(rd_ptr);
      case ({push, do_pop})
        2'b10:   occ <= occ + CW'(1);
        2'b01:   occ <= occ - CW'(1);
        default: occ <= occ;
      endcase
    end
  end

endmodule

// File: rtl/boot_rom_fetch_if.sv
// Fetch request/grant/response adapter in front of the synchronous boot ROM:
// decodes byte addresses, flags bad fetches, and queues responses under credit control.
module boot_rom_fetch_if #(
  parameter int unsigned ROM_WORDS  = boot_rom_pkg::ROM_WORDS,
  parameter logic [31:0] BASE_ADDR  = boot_rom_pkg::BOOT_BASE_ADDR,
  parameter int          RESP_DEPTH = 2
) (
  input  logic        CLK,
  input  logic        RSTN,
  input  logic        req_i,
  input  logic [31:0] addr_i,
  output logic        gnt_o,
  output logic        rvalid_o,
  output logic [31:0] rdata_o,
  output logic        err_o,
  input  logic        rready_i,
  output logic        rom_csn_o,
  output logic [9:0]  rom_a_o,
  input  logic [31:0] rom_q_i
);
  import boot_rom_pkg::*;

  localparam int CW = $clog2(RESP_DEPTH + 1);

  // Handshakes: a request transfers when req_i & gnt_o; a response transfers
  // when rvalid_o & rready_i. rvalid_o never drops and rdata_o/err_o never
  // change until the response has transferred.

  logic [31:0]   word_idx;
  logic          in_range;
  logic          rom_sel;
  logic          pop;
  logic          inflight_q;
  logic          inflight_err_q;
  logic [CW-1:0] occ;
  logic [CW:0]   credit;
  logic          fifo_empty;
  rom_resp_t     head;
  rom_resp_t     push_data;

  assign word_idx = (addr_i - BASE_ADDR) >> 2;
  assign in_range = (addr_i >= BASE_ADDR) && (word_idx < ROM_WORDS) &&
                    (addr_i[1:0] == 2'b00);

  // Credits count every slot already promised: queued entries plus the fetch
  // whose ROM data lands this cycle, minus the entry leaving right now.
  assign pop    = rvalid_o & rready_i;
  assign credit = {1'b0, occ} + {{CW{1'b0}}, inflight_q} - {{CW{1'b0}}, pop};
  assign gnt_o  = req_i & (credit < (CW+1)'(RESP_DEPTH));

  assign rom_sel   = RSTN & gnt_o & in_range;
  assign rom_csn_o = ~rom_sel;
  assign rom_a_o   = rom_sel ? word_idx[9:0] : '0;

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      inflight_q     <= 1'b0;
      inflight_err_q <= 1'b0;
    end else begin
      inflight_q     <= gnt_o;
      inflight_err_q <= gnt_o & ~in_range;
    end
  end

  assign push_data.rdata = inflight_err_q ? '0 : rom_q_i;
  assign push_data.err   = inflight_err_q;

  boot_rom_resp_fifo #(
    .DEPTH (RESP_DEPTH)
  ) u_resp_fifo (
    .CLK       (CLK),
    .RSTN      (RSTN),
    .push      (inflight_q),
    .push_data (push_data),
    .pop       (pop),
    .head      (head),
    .occ       (occ),
    .empty     (fifo_empty)
  );

  assign rvalid_o = ~fifo_empty;
  assign rdata_o  = rvalid_o ? head.rdata : '0;
  assign err_o    = rvalid_o & head.err;

endmodule

// File: tb/tb_boot_rom_fetch_if.sv
// Directed + random bench for boot_rom_fetch_if with a transaction-level response model.
module tb_boot_rom_fetch_if;

  localparam int          DEPTH = 2;
  localparam int          WORDS = 800;
  localparam logic [31:0] BASE  = 32'h0000_8000;

  logic        CLK = 1'b0;
  logic        RSTN;
  logic        req_i;
  logic [31:0] addr_i;
  logic        gnt_o;
  logic        rvalid_o;
  logic [31:0] rdata_o;
  logic        err_o;
  logic        rready_i;
  logic        rom_csn_o;
  logic [9:0]  rom_a_o;
  logic [31:0] rom_q_i;

  boot_rom_fetch_if #(
    .ROM_WORDS  (WORDS),
    .BASE_ADDR  (BASE),
    .RESP_DEPTH (DEPTH)
  ) dut (
    .CLK       (CLK),
    .RSTN      (RSTN),
    .req_i     (req_i),
    .addr_i    (addr_i),
    .gnt_o     (gnt_o),
    .rvalid_o  (rvalid_o),
    .rdata_o   (rdata_o),
    .err_o     (err_o),
    .rready_i  (rready_i),
    .rom_csn_o (rom_csn_o),
    .rom_a_o   (rom_a_o),
    .rom_q_i   (rom_q_i)
  );

  // clock / ROM behaviour
  always #5 CLK = ~CLK;

  logic [31:0] rom_mem [WORDS];
  always @(posedge CLK) if (!rom_csn_o) rom_q_i <= rom_mem[rom_a_o];

  // scoreboard: {err, data} per accepted fetch, plus the cycle it may appear
  int          n_assert = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  logic [32:0] exp_q[$];
  int          rdy_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit model_in_range(input logic [31:0] a, output int idx);
    longint off;
    off = a;
    off = off - longint'(BASE);
    idx = int'(off / 4);
    return (off >= 0) && (off % 4 == 0) && (off / 4 < WORDS);
  endfunction

  // One clock: check outputs at the falling edge, update the model, return grant.
  task automatic tick(output bit g);
    bit   inr;
    bit   exp_rv;
    bit   pop;
    bit   exp_g;
    int   idx;
    @(negedge CLK);
    cyc++;
    g = gnt_o;
    if (!RSTN) begin
      exp_q.delete();
      rdy_q.delete();
      chk("rst_rvalid", 32'(rvalid_o), 32'd0);
      chk("rst_rdata", rdata_o, 32'd0);
      chk("rst_err", 32'(err_o), 32'd0);
      chk("rst_csn", 32'(rom_csn_o), 32'd1);
      chk("rst_rom_a", 32'(rom_a_o), 32'd0);
      chk("rst_gnt", 32'(gnt_o), 32'(req_i));
      g = 1'b0;
    end else begin
      exp_rv = (exp_q.size() > 0) && (rdy_q[0] <= cyc);
      chk("rvalid", 32'(rvalid_o), 32'(exp_rv));
      if (exp_rv) begin
        chk("rdata", rdata_o, exp_q[0][31:0]);
        chk("err", 32'(err_o), 32'(exp_q[0][32]));
      end
      pop   = exp_rv & rready_i;
      exp_g = req_i && ((exp_q.size() - int'(pop)) < DEPTH);
      chk("gnt", 32'(gnt_o), 32'(exp_g));
      inr = model_in_range(addr_i, idx);
      if (gnt_o) begin
        chk("csn_on_gnt", 32'(rom_csn_o), 32'(!inr));
        chk("rom_a_on_gnt", 32'(rom_a_o), inr ? 32'(idx) : 32'd0);
      end else begin
        chk("csn_idle", 32'(rom_csn_o), 32'd1);
      end
      if (pop) begin
        void'(exp_q.pop_front());
        void'(rdy_q.pop_front());
      end
      if (gnt_o && exp_g) begin
        exp_q.push_back(inr ? {1'b0, rom_mem[idx]} : {1'b1, 32'd0});
        rdy_q.push_back(cyc + 2);
      end
    end
    @(posedge CLK);
    #1;
  endtask

  // driver tasks
  task automatic send(input logic [31:0] a, output int gc);
    bit g = 1'b0;
    req_i  = 1'b1;
    addr_i = a;
    gc     = -1;
    for (int i = 0; i < 20 && !g; i++) begin
      tick(g);
      if (g) gc = cyc;
    end
    chk("send_timeout", 32'(g), 32'd1);
  endtask

  task automatic idle(input int n);
    bit g;
    req_i = 1'b0;
    for (int i = 0; i < n; i++) tick(g);
  endtask

  initial begin
    bit          g;
    int          gc;
    int          gcs[4];
    int          ng;
    logic [31:0] b2b[4];
    logic [31:0] a;

    for (int i = 0; i < WORDS; i++) rom_mem[i] = $urandom;
    rom_mem[0]  = 32'h0000_0013;
    rom_mem[1]  = 32'h0000_0013;
    rom_mem[31] = 32'h0100_006F;
    rom_mem[32] = 32'h0100_006F;
    rom_mem[33] = 32'h0080_006F;
    rom_mem[34] = 32'h0040_006F;

    // reset: grant follows request, ROM deselected
    RSTN     = 1'b0;
    req_i    = 1'b1;
    addr_i   = 32'h0000_8000;
    rready_i = 1'b1;
    repeat (3) tick(g);
    req_i = 1'b0;
    RSTN  = 1'b1;
    idle(2);

    // single fetch
    send(32'h0000_8000, gc);
    idle(4);

    // back-to-back
    b2b = '{32'h0000_807C, 32'h0000_8080, 32'h0000_8084, 32'h0000_8088};
    for (int i = 0; i < 4; i++) send(b2b[i], gcs[i]);
    idle(5);
    chk("b2b_consecutive", 32'(gcs[3] - gcs[0]), 32'd3);

    // backpressure stall, then drain with grants restarting
    rready_i = 1'b0;
    req_i    = 1'b1;
    addr_i   = BASE + 32'(4 * $urandom_range(0, WORDS - 1));
    ng       = 0;
    repeat (6) begin
      tick(g);
      ng += int'(g);
    end
    chk("stall_grants", 32'(ng), 32'd2);
    rready_i = 1'b1;
    repeat (4) tick(g);
    idle(4);

    // out-of-range, below-base, misaligned, and the last valid word
    send(32'h0000_8C80, gc);
    send(32'h0000_7FFC, gc);
    send(32'h0000_8002, gc);
    send(32'h0000_8C7C, gc);
    idle(4);

    // interleaved good/bad fetches keep order
    send(32'h0000_8000, gc);
    send(32'h0000_9000, gc);
    send(32'h0000_8004, gc);
    idle(4);

    // reset with one entry queued and one in flight
    rready_i = 1'b0;
    send(32'h0000_8000, gc);
    idle(2);
    send(32'h0000_8004, gc);
    RSTN  = 1'b0;
    req_i = 1'b0;
    tick(g);
    RSTN     = 1'b1;
    rready_i = 1'b1;
    idle(4);
    send(32'h0000_8000, gc);
    idle(4);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 5))
        0, 1:    a = BASE + 32'(4 * $urandom_range(0, WORDS - 1));
        2:       a = 32'h0000_8C7C + 32'(4 * $urandom_range(0, 1));
        3:       a = BASE - 32'(4 * $urandom_range(1, 4));
        4:       a = BASE + 32'($urandom_range(0, 4 * WORDS - 1));
        default: a = $urandom;
      endcase
      req_i    = ($urandom_range(0, 3) != 0);
      addr_i   = a;
      rready_i = ($urandom_range(0, 3) != 0);
      tick(g);
    end
    rready_i = 1'b1;
    idle(6);
    chk("final_drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/boot_rom_fetch_if.md
# boot_rom_fetch_if

Bus-side adapter that sits directly upstream of the boot ROM. It converts the instruction-fetch request/grant/response protocol into the ROM's chip-select/address interface. The ROM registers its address and returns Q from that registered address, so data is valid one cycle after select. The adapter translates byte addresses to word indices, rejects out-of-range or misaligned fetches with an error response, and buffers responses in a small FIFO so the consumer may apply backpressure.

## Interface
Parameters:
- ROM_WORDS, 800: number of 32-bit ROM words; valid word index is 0..ROM_WORDS-1.
- BASE_ADDR, 32'h0000_8000: byte address of ROM word 0.
- RESP_DEPTH, 2: response FIFO depth; must be ≥ 2.

Ports:
- CLK  in  1  clock.
- RSTN  in  1  reset, asynchronous, active-low.
- req_i  in  1  fetch request.
- addr_i  in  32  byte address, sampled when req_i & gnt_o.
- gnt_o  out  1  request accepted this cycle.
- rvalid_o  out  1  response valid.
- rdata_o  out  32  response data; 0 when err_o=1.
- err_o  out  1  response is an error.
- rready_i  in  1  consumer accepts the response this cycle.
- rom_csn_o  out  1  ROM chip select, active-low.
- rom_a_o  out  10  ROM word index.
- rom_q_i  in  32  ROM data, valid the cycle after rom_csn_o=0.

## Operation
- Word index is (addr_i − BASE_ADDR) >> 2.
- A fetch is in range when all three hold: addr_i ≥ BASE_ADDR, index < ROM_WORDS, and addr_i[1:0] = 0.
- Credit count is occ + inflight − pop, where:
  - occ = FIFO occupancy,
  - inflight = 1 if a grant happened last cycle,
  - pop = rvalid_o & rready_i.
- gnt_o = req_i & (credit count < RESP_DEPTH). The path from rready_i to gnt_o is combinational by design.
- On a grant with an in-range fetch:
  - rom_csn_o = 0 and rom_a_o = index[9:0] in the same cycle.
  - In-flight flag is set with err = 0.
- On a grant with an out-of-range fetch:
  - rom_csn_o stays 1 and no ROM access occurs.
  - In-flight flag is set with err = 1.
- Cycle after a grant: push {rom_q_i, 0} into the FIFO, or {0, 1} for an error fetch. rom_q_i is sampled only in this cycle.
- The FIFO head drives rvalid_o, rdata_o and err_o. An entry pops on rvalid_o & rready_i.
- Responses are returned strictly in request order.
- rom_a_o is don't-care when rom_csn_o = 1. It is driven to 0 in that case for determinism.
- Simultaneous push and pop keeps occupancy unchanged. With RESP_DEPTH ≥ 2 a push never hits a full FIFO, because credits guarantee space.

## Timing
- Reset values:
  - gnt_o follows req_i (credits are free).
  - rvalid_o = 0, rdata_o = 0, err_o = 0, rom_a_o = 0.
  - rom_csn_o = 1, and is forced to 1 while RSTN is low.
- Latency: grant in cycle N → rvalid_o in cycle N+2 when the FIFO is empty (registered response).
- Throughput: 1 fetch per cycle sustained while rready_i = 1.
- Stall: with rready_i = 0, at most RESP_DEPTH grants are issued. gnt_o is then 0 until a pop.
- rdata_o and err_o are stable while rvalid_o & ~rready_i.
- Reset asserted mid-operation: in-flight and FIFO entries are discarded. No response is produced for pre-reset requests.

## Structure
- Package boot_rom_pkg holds:
  - ROM_WORDS and BOOT_BASE_ADDR constants.
  - rom_resp_t, a packed struct {logic [31:0] rdata; logic err}.
- Sub-module boot_rom_resp_fifo: generic RESP_DEPTH-entry FIFO of rom_resp_t with push/pop/occupancy. Pointer wrap-around is modulo RESP_DEPTH.
- The top level contains only the decode, credit logic and in-flight register.

## Test plan
- Single fetch 0x0000_8000, rready_i = 1: gnt in N, rom_csn_o = 0 and rom_a_o = 0 in N, rvalid_o in N+2 with rdata_o = 0x00000013, err_o = 0.
- Fetches at 0x807C, 0x8080, 0x8084, 0x8088 back-to-back, rready_i = 1: gnt_o high 4 consecutive cycles; responses 0x0100006F, 0x0100006F, 0x0080006F, 0x0040006F in 4 consecutive cycles.
- rready_i = 0 with a continuous request stream: exactly 2 grants, then gnt_o = 0. rvalid_o stays high with head data stable. Raising rready_i drains in order and restarts grants the same cycle.
- Out-of-range fetches 0x0000_8C80 (index 800), 0x0000_7FFC (below base) and misaligned 0x0000_8002: rom_csn_o stays 1; rvalid_o with err_o = 1 and rdata_o = 0.
- Interleave: valid 0x8000, invalid 0x9000, valid 0x8004: responses 0x00000013 (err 0), 0 (err 1), 0x00000013 (err 0), in order.
- Assert RSTN low in the cycle after a grant with one entry already queued: after release rvalid_o = 0, no stale response appears, and the next fetch behaves as the single-fetch case.
